// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered arithmetic unit between two
// requesters; divide-by-zero is trapped before issue and answered directly.
module alu_req_arbiter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  Clk,
  input  logic                  RST,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [DATA_WIDTH-1:0] req0_A,
  input  logic [DATA_WIDTH-1:0] req0_B,
  input  logic [DATA_WIDTH-1:0] req1_A,
  input  logic [DATA_WIDTH-1:0] req1_B,
  input  logic [1:0]            req0_fun,
  input  logic [1:0]            req1_fun,
  output logic [DATA_WIDTH-1:0] au_A,
  output logic [DATA_WIDTH-1:0] au_B,
  output logic [1:0]            au_fun,
  output logic                  au_enable,
  input  logic [DATA_WIDTH-1:0] au_out,
  input  logic                  au_flag,
  input  logic                  au_carry,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_carry,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state;
  logic                  last_id;
  logic                  grant_any;
  logic                  grant_id;
  logic                  div_zero;
  logic [DATA_WIDTH-1:0] sel_A;
  logic [DATA_WIDTH-1:0] sel_B;
  logic [1:0]            sel_fun;

  // Accept strobe is combinational so the requester sees it in the cycle its operands are latched
  always_comb begin
    grant_any = RST && (state == IDLE) && (req_valid != 2'b00);
    grant_id  = (req_valid == 2'b11) ? ~last_id : req_valid[1];
    sel_A     = grant_id ? req1_A : req0_A;
    sel_B     = grant_id ? req1_B : req0_B;
    sel_fun   = grant_id ? req1_fun : req0_fun;
    div_zero  = (sel_fun == 2'b11) && (sel_B == '0);
    req_ready = 2'b00;
    if (grant_any) begin
      req_ready = grant_id ? 2'b10 : 2'b01;
    end
  end

  // last_id resets to 1 so that the first contention goes to requester 0
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      last_id   <= 1'b1;
      au_A      <= '0;
      au_B      <= '0;
      au_fun    <= 2'b00;
      au_enable <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            au_A    <= sel_A;
            au_B    <= sel_B;
            au_fun  <= sel_fun;
            rsp_id  <= grant_id;
            last_id <= grant_id;
            if (div_zero) begin
              rsp_data  <= '0;
              rsp_carry <= 1'b0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              au_enable <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          au_enable <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          rsp_data  <= au_out;
          rsp_carry <= au_carry;
          rsp_err   <= ~au_flag;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed scenarios plus random traffic checked against a
// transaction-level model of grant order, latency and expected results.
module tb_alu_req_arbiter;
  localparam int DW = 16;

  logic          Clk = 1'b0;
  logic          RST = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [DW-1:0] req0_A = '0, req0_B = '0, req1_A = '0, req1_B = '0;
  logic [1:0]    req0_fun = 2'b00, req1_fun = 2'b00;
  logic [DW-1:0] au_A, au_B;
  logic [1:0]    au_fun;
  logic          au_enable;
  logic [DW-1:0] au_out = '0;
  logic          au_flag = 1'b0, au_carry = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_id;
  logic [DW-1:0] rsp_data;
  logic          rsp_carry, rsp_err;
  logic          drop_flag = 1'b0;

  int checks = 0;
  int errors = 0;

  // model state
  bit            m_free = 1'b1;
  logic          m_last = 1'b1;
  logic          m_id = 1'b0, m_carry = 1'b0, m_err = 1'b0;
  logic [DW-1:0] m_a = '0, m_b = '0, m_data = '0;
  logic [1:0]    m_fun = 2'b00;
  int            m_due = 0, m_en_cyc = -1, m_acc_cyc = 0, cyc = 0;

  // observations exported to directed steps
  bit            acc = 1'b0, rsp_new = 1'b0;
  logic          acc_id = 1'b0, seen_id = 1'b0, seen_err = 1'b0;
  logic [DW-1:0] seen_data = '0;
  int            seen_lat = 0, en_count = 0, gcount = 0;

  alu_req_arbiter #(.DATA_WIDTH(DW)) dut (
    .Clk(Clk), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_A(req0_A), .req0_B(req0_B), .req1_A(req1_A), .req1_B(req1_B),
    .req0_fun(req0_fun), .req1_fun(req1_fun),
    .au_A(au_A), .au_B(au_B), .au_fun(au_fun), .au_enable(au_enable),
    .au_out(au_out), .au_flag(au_flag), .au_carry(au_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
  );

  always #5 Clk = ~Clk;

  function automatic logic [DW:0] alu_calc(input logic [1:0] f, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    p = a * b;
    case (f)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a} - {1'b0, b};
      2'b10:   return {|p[2*DW-1:DW], p[DW-1:0]};
      default: return (b == '0) ? {1'b0, {DW{1'b1}}} : {1'b0, a / b};
    endcase
  endfunction

  // Registered arithmetic unit stand-in; drop_flag suppresses its valid flag
  always @(posedge Clk) begin
    if (au_enable) begin
      {au_carry, au_out} <= alu_calc(au_fun, au_A, au_B);
      au_flag <= ~drop_flag;
    end else begin
      au_flag <= 1'b0;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    check_output({tag, "_au_A"}, 32'(au_A), 32'h0);
    check_output({tag, "_au_B"}, 32'(au_B), 32'h0);
    check_output({tag, "_au_fun"}, 32'(au_fun), 32'h0);
    check_output({tag, "_au_enable"}, 32'(au_enable), 32'h0);
    check_output({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check_output({tag, "_rsp_id"}, 32'(rsp_id), 32'h0);
    check_output({tag, "_rsp_data"}, 32'(rsp_data), 32'h0);
    check_output({tag, "_rsp_carry"}, 32'(rsp_carry), 32'h0);
    check_output({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
  endtask

  task automatic model_reset();
    m_free = 1'b1;
    m_last = 1'b1;
    m_en_cyc = -1;
  endtask

  task automatic apply_stimulus(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [1:0] f);
    if (i == 0) begin
      req0_A = a; req0_B = b; req0_fun = f;
    end else begin
      req1_A = a; req1_B = b; req1_fun = f;
    end
    req_valid[i] = 1'b1;
  endtask

  // One clock cycle: settle, check against the model, advance to the next negedge
  task automatic check_cycle();
    logic [1:0]    exp_rdy;
    logic          gid;
    logic [DW:0]   r;
    bit            exp_v;
    bit            exp_en;
    #1;
    acc = 1'b0;
    rsp_new = 1'b0;
    exp_rdy = 2'b00;
    if (m_free && req_valid != 2'b00) begin
      gid = (req_valid == 2'b11) ? ~m_last : req_valid[1];
      exp_rdy = gid ? 2'b10 : 2'b01;
      m_id = gid; m_last = gid; m_free = 1'b0;
      acc = 1'b1; acc_id = gid; m_acc_cyc = cyc;
      m_a = gid ? req1_A : req0_A;
      m_b = gid ? req1_B : req0_B;
      m_fun = gid ? req1_fun : req0_fun;
      if (m_fun == 2'b11 && m_b == '0) begin
        m_due = cyc + 1; m_en_cyc = -1;
        m_data = '0; m_carry = 1'b0; m_err = 1'b1;
      end else begin
        r = alu_calc(m_fun, m_a, m_b);
        m_due = cyc + 3; m_en_cyc = cyc + 1;
        m_data = r[DW-1:0]; m_carry = r[DW]; m_err = drop_flag;
      end
    end
    check_output("req_ready", 32'(req_ready), 32'(exp_rdy));
    exp_en = (cyc == m_en_cyc);
    check_output("au_enable", 32'(au_enable), 32'(exp_en));
    if (au_enable) en_count++;
    if (exp_en) begin
      check_output("au_A", 32'(au_A), 32'(m_a));
      check_output("au_B", 32'(au_B), 32'(m_b));
      check_output("au_fun", 32'(au_fun), 32'(m_fun));
    end
    exp_v = !m_free && (cyc >= m_due);
    check_output("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    if (exp_v) begin
      check_output("rsp_id", 32'(rsp_id), 32'(m_id));
      check_output("rsp_data", 32'(rsp_data), 32'(m_data));
      check_output("rsp_carry", 32'(rsp_carry), 32'(m_carry));
      check_output("rsp_err", 32'(rsp_err), 32'(m_err));
      if (cyc == m_due) begin
        rsp_new = 1'b1;
        seen_lat = cyc - m_acc_cyc;
        seen_id = rsp_id; seen_data = rsp_data; seen_err = rsp_err;
      end
      if (rsp_ready) m_free = 1'b1;
    end
    @(negedge Clk);
    cyc++;
    if (acc) req_valid[acc_id] = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge Clk);
    #1;
    check_reset_outputs("reset");
    @(negedge Clk);
    RST = 1'b1;
    model_reset();
    rsp_ready = 1'b1;

    // contention: grants alternate starting with requester 0, both results 0x000F
    $display("[TB] contention");
    gcount = 0;
    for (int k = 0; k < 18; k++) begin
      apply_stimulus(0, 16'h0010, 16'h0001, 2'b01);
      apply_stimulus(1, 16'h0003, 16'h0005, 2'b10);
      check_cycle();
      if (acc) begin
        check_output("cont_grant", 32'(acc_id), 32'(gcount % 2));
        gcount++;
      end
      if (rsp_new) check_output("cont_data", 32'(seen_data), 32'h000F);
    end
    check_output("cont_grants", 32'(gcount >= 4), 32'h1);
    req_valid = 2'b00;
    repeat (5) check_cycle();

    // single add
    $display("[TB] single add");
    en_count = 0;
    apply_stimulus(0, 16'h0003, 16'h0004, 2'b00);
    repeat (6) check_cycle();
    check_output("add_lat", 32'(seen_lat), 32'd3);
    check_output("add_id", 32'(seen_id), 32'h0);
    check_output("add_data", 32'(seen_data), 32'h0007);
    check_output("add_err", 32'(seen_err), 32'h0);
    check_output("add_en_count", 32'(en_count), 32'd1);

    // divide-by-zero trap, then a legal divide
    $display("[TB] divide by zero");
    en_count = 0;
    apply_stimulus(1, 16'h1234, 16'h0000, 2'b11);
    repeat (4) check_cycle();
    check_output("dz_lat", 32'(seen_lat), 32'd1);
    check_output("dz_id", 32'(seen_id), 32'h1);
    check_output("dz_data", 32'(seen_data), 32'h0);
    check_output("dz_err", 32'(seen_err), 32'h1);
    check_output("dz_en_count", 32'(en_count), 32'd0);
    apply_stimulus(1, 16'h0064, 16'h0005, 2'b11);
    repeat (6) check_cycle();
    check_output("div_data", 32'(seen_data), 32'h0014);
    check_output("div_err", 32'(seen_err), 32'h0);

    // backpressure: stalled response, pending request must wait
    $display("[TB] backpressure");
    apply_stimulus(0, 16'h0100, 16'h0020, 2'b00);
    repeat (3) check_cycle();
    rsp_ready = 1'b0;
    apply_stimulus(0, 16'h0005, 16'h0006, 2'b00);
    repeat (5) check_cycle();
    rsp_ready = 1'b1;
    check_cycle();
    check_cycle();
    check_output("bp_next_accept", 32'(acc), 32'h1);
    repeat (5) check_cycle();

    // reset while in WAIT
    $display("[TB] reset mid-operation");
    apply_stimulus(0, 16'h0003, 16'h0004, 2'b00);
    repeat (2) check_cycle();
    #2;
    RST = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(negedge Clk);
    cyc++;
    RST = 1'b1;
    repeat (3) check_cycle();
    apply_stimulus(0, 16'h0003, 16'h0004, 2'b00);
    repeat (5) check_cycle();
    check_output("post_reset_data", 32'(seen_data), 32'h0007);
    check_output("post_reset_lat", 32'(seen_lat), 32'd3);

    // missing unit flag reports an error but keeps the unit's data
    $display("[TB] missing au_flag");
    drop_flag = 1'b1;
    apply_stimulus(1, 16'h00FF, 16'h0002, 2'b10);
    repeat (5) check_cycle();
    check_output("noflag_err", 32'(seen_err), 32'h1);
    check_output("noflag_data", 32'(seen_data), 32'h01FE);
    drop_flag = 1'b0;

    // random traffic
    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          apply_stimulus(i, 16'($urandom),
                         ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
                         2'($urandom));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      check_cycle();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (6) check_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
